// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite bundle shared by the arbiter's requesters and its downstream port.
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// AXI4-Lite N:1 arbiter with one outstanding transaction on the shared bus.
// Master 0 is instruction fetch, master 1 is load/store.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the
// lowest-index requester wins and no pointer register is built.
module axi_lite_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    axi_lite_if.slave                      m [NUM_MASTERS],
    axi_lite_if.master                     s,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           busy
);
    localparam int GW = $clog2(NUM_MASTERS);
    localparam int SW = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          busy_q, busy_d;

    // Flattened per-master views of the interface array
    logic [NUM_MASTERS-1:0]             m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
    logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_araddr, m_awaddr;
    logic [NUM_MASTERS-1:0][2:0]        m_arprot, m_awprot;
    logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0][SW-1:0]     m_wstrb;
    logic [NUM_MASTERS-1:0]             m_arready, m_awready, m_wready, m_rvalid, m_bvalid;
    logic [NUM_MASTERS-1:0][DATA_W-1:0] m_rdata;
    logic [NUM_MASTERS-1:0][1:0]        m_rresp, m_bresp;

    // Downstream drive, gated by state so idle/reset leaves the bus quiet
    logic              s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
    logic [ADDR_W-1:0] s_araddr, s_awaddr;
    logic [2:0]        s_arprot, s_awprot;
    logic [DATA_W-1:0] s_wdata;
    logic [SW-1:0]     s_wstrb;

    logic [NUM_MASTERS-1:0] req;
    logic [GW-1:0]          win;
    logic [GW-1:0]          next_ptr;
    logic                   ar_hs, aw_hs, w_hs, r_hs, b_hs;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
        assign m_arvalid[i] = m[i].arvalid;
        assign m_araddr[i]  = m[i].araddr;
        assign m_arprot[i]  = m[i].arprot;
        assign m_awvalid[i] = m[i].awvalid;
        assign m_awaddr[i]  = m[i].awaddr;
        assign m_awprot[i]  = m[i].awprot;
        assign m_wvalid[i]  = m[i].wvalid;
        assign m_wdata[i]   = m[i].wdata;
        assign m_wstrb[i]   = m[i].wstrb;
        assign m_rready[i]  = m[i].rready;
        assign m_bready[i]  = m[i].bready;
        assign m[i].arready = m_arready[i];
        assign m[i].awready = m_awready[i];
        assign m[i].wready  = m_wready[i];
        assign m[i].rvalid  = m_rvalid[i];
        assign m[i].rdata   = m_rdata[i];
        assign m[i].rresp   = m_rresp[i];
        assign m[i].bvalid  = m_bvalid[i];
        assign m[i].bresp   = m_bresp[i];
    end

    assign s.arvalid = s_arvalid;
    assign s.araddr  = s_araddr;
    assign s.arprot  = s_arprot;
    assign s.awvalid = s_awvalid;
    assign s.awaddr  = s_awaddr;
    assign s.awprot  = s_awprot;
    assign s.wvalid  = s_wvalid;
    assign s.wdata   = s_wdata;
    assign s.wstrb   = s_wstrb;
    assign s.rready  = s_rready;
    assign s.bready  = s_bready;

    assign grant_id = grant_q;
    assign busy     = busy_q;

    assign req      = m_arvalid | m_awvalid;
    assign ar_hs    = s_arvalid && s.arready;
    assign aw_hs    = s_awvalid && s.awready;
    assign w_hs     = s_wvalid && s.wready;
    assign r_hs     = s.rvalid && s_rready;
    assign b_hs     = s.bvalid && s_bready;
    assign next_ptr = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + GW'(1);

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] ptr_q, ptr_d;

    // Round-robin pick: walk backwards so the first requester after ptr wins
    always_comb begin
        win = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % NUM_MASTERS]) win = GW'((int'(ptr_q) + k) % NUM_MASTERS);
        end
    end

    // Pointer advances past the master whose response just completed
    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == RD_RESP && r_hs) || (state_q == WR_RESP && b_hs)) ptr_d = next_ptr;
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    // Fixed priority: lowest index wins
    always_comb begin
        win = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (req[k]) win = GW'(k);
        end
    end
`endif

    // Next-state: arbitrate in IDLE, then track the single transaction to completion
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = win;
                    state_d = m_arvalid[win] ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: if (ar_hs) state_d = RD_RESP;
            RD_RESP: begin
                if (r_hs) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            WR_REQ: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = IDLE;
                    grant_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            busy_q    <= busy_d;
        end
    end

    // Channel routing between the granted master and the shared bus
    always_comb begin
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arprot  = '0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awprot  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_rready  = 1'b0;
        s_bready  = 1'b0;
        m_arready = '0;
        m_awready = '0;
        m_wready  = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        case (state_q)
            RD_ADDR: begin
                s_arvalid          = m_arvalid[grant_q];
                s_araddr           = m_araddr[grant_q];
                s_arprot           = m_arprot[grant_q];
                m_arready[grant_q] = s.arready;
            end
            RD_RESP: begin
                s_rready          = m_rready[grant_q];
                m_rvalid[grant_q] = s.rvalid;
                m_rdata[grant_q]  = s.rdata;
                m_rresp[grant_q]  = s.rresp;
            end
            WR_REQ: begin
                // Each channel goes quiet once its own handshake has happened
                if (!aw_done_q) begin
                    s_awvalid          = m_awvalid[grant_q];
                    s_awaddr           = m_awaddr[grant_q];
                    s_awprot           = m_awprot[grant_q];
                    m_awready[grant_q] = s.awready;
                end
                if (!w_done_q) begin
                    s_wvalid          = m_wvalid[grant_q];
                    s_wdata           = m_wdata[grant_q];
                    s_wstrb           = m_wstrb[grant_q];
                    m_wready[grant_q] = s.wready;
                end
            end
            WR_RESP: begin
                s_bready          = m_bready[grant_q];
                m_bvalid[grant_q] = s.bvalid;
                m_bresp[grant_q]  = s.bresp;
            end
            default: ;
        endcase
    end

    // Granted master must keep its valids up until the handshake
    a_ar_hold: assert property (@(posedge clk) disable iff (!reset)
        (state_q == RD_ADDR) |-> m_arvalid[grant_q]);
    a_aw_hold: assert property (@(posedge clk) disable iff (!reset)
        (state_q == WR_REQ && !aw_done_q) |-> m_awvalid[grant_q]);
    a_w_hold: assert property (@(posedge clk) disable iff (!reset)
        (state_q == WR_REQ && !w_done_q && m_wvalid[grant_q] && !s.wready) |=> m_wvalid[grant_q]);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: bench drives both masters and the slave.
module tb_axi_lite_arbiter;
    logic       clk;
    logic       rst_n;
    logic [0:0] grant_id;
    logic       busy;
    int         total = 0;
    int         bad   = 0;
    int         aw_cnt = 0;
    int         w_cnt  = 0;

    axi_lite_if mif[2] ();
    axi_lite_if sif ();

    axi_lite_arbiter #(.NUM_MASTERS(2)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .m        (mif),
        .s        (sif),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count handshakes on the shared bus mid-cycle
    always @(negedge clk) begin
        if (sif.awvalid && sif.awready) aw_cnt++;
        if (sif.wvalid && sif.wready)   w_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Caller raises the request in IDLE; returns one cycle after the r handshake
    task automatic serve_read(input int g, input logic [31:0] data, input logic [1:0] resp);
        tick();
        chk("rd.grant", 32'(grant_id), 32'(g));
        chk("rd.arvalid", 32'(sif.arvalid), 32'd1);
        chk("rd.busy", 32'(busy), 32'd1);
        sif.arready = 1'b1;
        tick();
        sif.arready = 1'b0;
        sif.rvalid  = 1'b1;
        sif.rdata   = data;
        sif.rresp   = resp;
        #1;
        if (g == 0) begin
            chk("rd.m0.rvalid", 32'(mif[0].rvalid), 32'd1);
            chk("rd.m0.rdata", mif[0].rdata, data);
            chk("rd.m0.rresp", 32'(mif[0].rresp), 32'(resp));
            chk("rd.m1.rvalid", 32'(mif[1].rvalid), 32'd0);
        end else begin
            chk("rd.m1.rvalid", 32'(mif[1].rvalid), 32'd1);
            chk("rd.m1.rdata", mif[1].rdata, data);
            chk("rd.m0.rvalid", 32'(mif[0].rvalid), 32'd0);
        end
        tick();
        sif.rvalid = 1'b0;
        #1;
        chk("rd.idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        mif[0].arvalid = 0; mif[0].araddr = 0; mif[0].arprot = 0; mif[0].rready = 1;
        mif[0].awvalid = 0; mif[0].awaddr = 0; mif[0].awprot = 0; mif[0].bready = 1;
        mif[0].wvalid  = 0; mif[0].wdata  = 0; mif[0].wstrb  = 0;
        mif[1].arvalid = 0; mif[1].araddr = 0; mif[1].arprot = 0; mif[1].rready = 1;
        mif[1].awvalid = 0; mif[1].awaddr = 0; mif[1].awprot = 0; mif[1].bready = 1;
        mif[1].wvalid  = 0; mif[1].wdata  = 0; mif[1].wstrb  = 0;
        sif.arready = 0; sif.awready = 0; sif.wready = 0;
        sif.rvalid = 0; sif.rdata = 0; sif.rresp = 0;
        sif.bvalid = 0; sif.bresp = 0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.grant", 32'(grant_id), 32'd0);
        chk("rst.svalids", {27'd0, sif.arvalid, sif.awvalid, sif.wvalid, sif.rready, sif.bready}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Contention: m0 read vs m1 write in the same cycle
        mif[0].arvalid = 1; mif[0].araddr = 32'h0000_1000;
        mif[1].awvalid = 1; mif[1].awaddr = 32'ha000_03f8;
        mif[1].wvalid  = 1; mif[1].wdata  = 32'h1234_5678; mif[1].wstrb = 4'hf;
        #1;
        chk("idle.no_ar", 32'(sif.arvalid), 32'd0);
        chk("idle.no_aw", 32'(sif.awvalid), 32'd0);
        tick();
        chk("ct.grant0", 32'(grant_id), 32'd0);
        chk("ct.araddr", sif.araddr, 32'h0000_1000);
        chk("ct.aw_blocked", 32'(sif.awvalid), 32'd0);
        sif.arready = 1; #1;
        chk("ct.m0.arready", 32'(mif[0].arready), 32'd1);
        chk("ct.m1.awready", 32'(mif[1].awready), 32'd0);
        tick();
        mif[0].arvalid = 0; sif.arready = 0;
        sif.rvalid = 1; sif.rdata = 32'h55; sif.rresp = 0; #1;
        chk("ct.m0.rdata", mif[0].rdata, 32'h55);
        tick();
        sif.rvalid = 0; #1;
        chk("ct.gap_idle", 32'(busy), 32'd0);
        tick();
        chk("ct.grant1", 32'(grant_id), 32'd1);
        chk("ct.awaddr", sif.awaddr, 32'ha000_03f8);
        chk("ct.wvalid", 32'(sif.wvalid), 32'd1);

        // W completes three cycles ahead of AW
        sif.wready = 1; #1;
        chk("wo.m1.wready", 32'(mif[1].wready), 32'd1);
        chk("wo.m1.awready", 32'(mif[1].awready), 32'd0);
        tick();
        mif[1].wvalid = 0; sif.wready = 0; #1;
        chk("wo.w_dropped", 32'(sif.wvalid), 32'd0);
        chk("wo.aw_still", 32'(sif.awvalid), 32'd1);
        tick();
        tick();
        chk("wo.still_busy", 32'(busy), 32'd1);
        sif.awready = 1; #1;
        chk("wo.m1.awready2", 32'(mif[1].awready), 32'd1);
        tick();
        mif[1].awvalid = 0; sif.awready = 0;
        sif.bvalid = 1; sif.bresp = 2'b00; #1;
        chk("wo.bready", 32'(sif.bready), 32'd1);
        chk("wo.m1.bvalid", 32'(mif[1].bvalid), 32'd1);
        chk("wo.m0.bvalid", 32'(mif[0].bvalid), 32'd0);
        tick();
        sif.bvalid = 0; #1;
        chk("wo.idle", 32'(busy), 32'd0);
        chk("wo.aw_cnt", 32'(aw_cnt), 32'd1);
        chk("wo.w_cnt", 32'(w_cnt), 32'd1);

        // AW and W complete together; SLVERR passes through
        mif[1].awvalid = 1; mif[1].awaddr = 32'h20;
        mif[1].wvalid  = 1; mif[1].wdata  = 32'hcafe;
        sif.awready = 1; sif.wready = 1; #1;
        chk("ws.idle_awready", 32'(mif[1].awready), 32'd0);
        tick();
        chk("ws.awvalid", 32'(sif.awvalid), 32'd1);
        chk("ws.wvalid", 32'(sif.wvalid), 32'd1);
        tick();
        mif[1].awvalid = 0; mif[1].wvalid = 0; sif.awready = 0; sif.wready = 0;
        sif.bvalid = 1; sif.bresp = 2'b10; #1;
        chk("ws.aw_dropped", 32'(sif.awvalid), 32'd0);
        chk("ws.m1.bresp", 32'(mif[1].bresp), 32'd2);
        chk("ws.m0.bvalid", 32'(mif[0].bvalid), 32'd0);
        tick();
        sif.bvalid = 0; #1;
        chk("ws.aw_cnt", 32'(aw_cnt), 32'd2);
        chk("ws.w_cnt", 32'(w_cnt), 32'd2);

        // Repeated dual read requests
        mif[0].arvalid = 1; mif[0].araddr = 32'h100;
        mif[1].arvalid = 1; mif[1].araddr = 32'h200;
        for (int i = 0; i < 4; i++) begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
            serve_read(i % 2, 32'h1000 + 32'(i), 2'b00);
`else
            serve_read(0, 32'h1000 + 32'(i), 2'b00);
`endif
        end
        mif[0].arvalid = 0;
`ifndef AXI_ARB_ROUND_ROBIN_EN
        serve_read(1, 32'h2000, 2'b00);
`endif
        mif[1].arvalid = 0;
        #1;

        // Single read, slave answers two cycles after AR
        mif[0].arvalid = 1; mif[0].araddr = 32'h8000_0000;
        tick();
        chk("sr.araddr", sif.araddr, 32'h8000_0000);
        sif.arready = 1;
        tick();
        mif[0].arvalid = 0; sif.arready = 0;
        tick();
        chk("sr.wait_rvalid", 32'(mif[0].rvalid), 32'd0);
        tick();
        sif.rvalid = 1; sif.rdata = 32'hdead_beef; sif.rresp = 0; #1;
        chk("sr.rdata", mif[0].rdata, 32'hdead_beef);
        chk("sr.rresp", 32'(mif[0].rresp), 32'd0);
        tick();
        sif.rvalid = 0; #1;
        chk("sr.busy_done", 32'(busy), 32'd0);

        // Reset during RD_RESP
        mif[0].arvalid = 1; mif[0].araddr = 32'h300;
        tick();
        sif.arready = 1;
        tick();
        mif[0].arvalid = 0; sif.arready = 0;
        sif.rvalid = 1; sif.rdata = 32'h77; #1;
        chk("mr.pre_rvalid", 32'(mif[0].rvalid), 32'd1);
        rst_n = 1'b0; #1;
        chk("mr.rvalid", 32'(mif[0].rvalid), 32'd0);
        chk("mr.rready", 32'(sif.rready), 32'd0);
        chk("mr.busy", 32'(busy), 32'd0);
        chk("mr.grant", 32'(grant_id), 32'd0);
        sif.rvalid = 0;
        tick();
        rst_n = 1'b1;

        // Read after reset, crossbar answers DECERR
        mif[0].arvalid = 1; mif[0].araddr = 32'h0;
        serve_read(0, 32'h0, 2'b11);
        mif[0].arvalid = 0;
        tick();
        chk("de.stay_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
